// File: rtl/rst_seq_pkg.sv
// Shared types and default timing for the reset sequencer.
// The cycle defaults assume a 50 MHz system clock.
package rst_seq_pkg;

    typedef enum logic [1:0] {
        HOLD_PHY  = 2'd0,
        WAIT_PHY  = 2'd1,
        WAIT_CORE = 2'd2,
        RUN       = 2'd3
    } rst_seq_state_e;

    localparam int PHY_RST_CYCLES_50M    = 500000;  // 10 ms
    localparam int PHY_WAIT_CYCLES_50M   = 250000;  // 5 ms
    localparam int CORE_DELAY_CYCLES_50M = 16;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/rst_seq_timer.sv
// Up-counter with synchronous clear/enable and an equality terminal-count
// compare against a runtime last value; it is cleared before it can wrap.
module rst_seq_timer #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic [CNT_W-1:0] last,
    output logic             tc
);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (en) begin
            count <= count + 1'b1;
        end
    end

    assign tc = (count == last);

endmodule

// File: rtl/rst_sequencer.sv
// Ordered reset release: PHY pin, then MAC, then core plus ready.
// state     | meaning
// HOLD_PHY  | PHY pin low; counting locked cycles toward PHY release
// WAIT_PHY  | PHY released; waiting for PHY settle / strap latch
// WAIT_CORE | MAC released; short delay before core release
// RUN       | all resets released, ready high
module rst_sequencer
    import rst_seq_pkg::*;
#(
    parameter int PHY_RST_CYCLES    = PHY_RST_CYCLES_50M,
    parameter int PHY_WAIT_CYCLES   = PHY_WAIT_CYCLES_50M,
    parameter int CORE_DELAY_CYCLES = CORE_DELAY_CYCLES_50M
) (
    input  logic clk,
    input  logic rst,
    input  logic pll_locked,
    input  logic soft_rst_req,
    output logic phy_rst_n,
    output logic mac_rst,
    output logic core_rst,
    output logic ready
);

    localparam int CNT_W = $clog2(max3(PHY_RST_CYCLES, PHY_WAIT_CYCLES, CORE_DELAY_CYCLES) + 1);

    rst_seq_state_e   state;
    rst_seq_state_e   state_next;
    logic             tmr_clr;
    logic             tmr_en;
    logic             tmr_tc;
    logic [CNT_W-1:0] tmr_last;
    logic             restart;

    assign restart = !pll_locked || soft_rst_req;

    always_comb begin
        tmr_last = '0;
        case (state)
            HOLD_PHY:  tmr_last = CNT_W'(PHY_RST_CYCLES - 1);
            WAIT_PHY:  tmr_last = CNT_W'(PHY_WAIT_CYCLES - 1);
            WAIT_CORE: tmr_last = CNT_W'(CORE_DELAY_CYCLES - 1);
            default:   tmr_last = '0;
        endcase
    end

    rst_seq_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk  (clk),
        .rst  (rst),
        .clr  (tmr_clr),
        .en   (tmr_en),
        .last (tmr_last),
        .tc   (tmr_tc)
    );

    // A restart always beats a terminal count arriving on the same cycle.
    always_comb begin
        state_next = state;
        tmr_clr    = 1'b0;
        tmr_en     = 1'b0;
        case (state)
            HOLD_PHY: begin
                if (restart) begin
                    tmr_clr = 1'b1;
                end else if (tmr_tc) begin
                    state_next = WAIT_PHY;
                    tmr_clr    = 1'b1;
                end else begin
                    tmr_en = 1'b1;
                end
            end
            WAIT_PHY: begin
                if (restart) begin
                    state_next = HOLD_PHY;
                    tmr_clr    = 1'b1;
                end else if (tmr_tc) begin
                    state_next = WAIT_CORE;
                    tmr_clr    = 1'b1;
                end else begin
                    tmr_en = 1'b1;
                end
            end
            WAIT_CORE: begin
                if (restart) begin
                    state_next = HOLD_PHY;
                    tmr_clr    = 1'b1;
                end else if (tmr_tc) begin
                    state_next = RUN;
                    tmr_clr    = 1'b1;
                end else begin
                    tmr_en = 1'b1;
                end
            end
            RUN: begin
                if (restart) begin
                    state_next = HOLD_PHY;
                    tmr_clr    = 1'b1;
                end
            end
            default: begin
                state_next = HOLD_PHY;
                tmr_clr    = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= HOLD_PHY;
        end else begin
            state <= state_next;
        end
    end

    // Outputs are decoded from the next state so they change on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            phy_rst_n <= 1'b0;
            mac_rst   <= 1'b1;
            core_rst  <= 1'b1;
            ready     <= 1'b0;
        end else begin
            phy_rst_n <= (state_next != HOLD_PHY);
            mac_rst   <= (state_next == HOLD_PHY) || (state_next == WAIT_PHY);
            core_rst  <= (state_next != RUN);
            ready     <= (state_next == RUN);
        end
    end

endmodule
